// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state encoding, default frame constants and counter-width helper
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS_DEF = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: clearable/loadable clock counter with terminal-count (CLKS-1) and half-count (CLKS/2-1) strobes
module uart_baud_cnt #(
  parameter int CLKS = 434,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tc,
  output logic         half
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : ld ? ld_val : cnt_q + W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == W'(CLKS - 1);
  assign half = cnt_q == W'(CLKS / 2 - 1);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer with one-deep valid/ready holding register; UART_RX_PARITY_EN adds even-parity check and parity_err
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 CLOCK,
  input  logic                 reset,
  input  logic                 Rx_out,
  input  logic                 f_edge,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam int BW = cnt_w(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
  logic par_q, par_d, perr_q, perr_d;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q, busy_d;
  logic clr, tc, half;
  uart_baud_cnt #(.CLKS(CLKS_PER_BIT), .W(CW)) u_cnt (
    .clk(CLOCK), .rst(reset), .clr(clr), .ld(1'b0), .ld_val(CW'(0)), .tc(tc), .half(half)
  );
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d = 1'b0;
    ovr_d = 1'b0;
    clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        state_d = f_edge ? START : IDLE;
      end
      START: if (half) begin
        clr = 1'b1;
        bit_d = '0;
        state_d = Rx_out ? IDLE : DATA;
      end
      DATA: if (tc) begin
        clr = 1'b1;
        shift_d = {Rx_out, shift_q[DATA_BITS-1:1]};
        bit_d = bit_q + BW'(1);
        state_d = (bit_q == BW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tc) begin
        clr = 1'b1;
        par_d = Rx_out;
        state_d = STOP;
      end
`endif
      STOP: if (tc) begin
        clr = 1'b1;
        state_d = IDLE;
        ferr_d = ~Rx_out;
`ifdef UART_RX_PARITY_EN
        perr_d = ^{shift_q, par_q};
`endif
        if (Rx_out) begin
          data_d = shift_q;
          valid_d = 1'b1;
          ovr_d = valid_q & ~rx_ready;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLOCK or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
      busy_q <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  assign rx_data = data_q;
  assign rx_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun = ovr_q;
  assign busy = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl at CLKS_PER_BIT=16, DATA_BITS=8
module tb_uart_rx_ctrl;
  logic CLOCK = 1'b0, reset = 1'b1, Rx_out = 1'b1, f_edge = 1'b0, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int n_vec = 0, n_err = 0;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .CLOCK(CLOCK), .reset(reset), .Rx_out(Rx_out), .f_edge(f_edge), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
  always #5 CLOCK = ~CLOCK;
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
    Rx_out = 1'b0;
    f_edge = 1'b1;
    tick();
    f_edge = 1'b0;
    repeat (15) tick();
    for (int i = 0; i < 8; i++) begin
      Rx_out = d[i];
      repeat (16) tick();
    end
`ifdef UART_RX_PARITY_EN
    Rx_out = ^d ^ par_flip;
    repeat (16) tick();
`else
    if (par_flip) Rx_out = 1'b1;
`endif
    Rx_out = stop;
    repeat (8) tick();
  endtask
  initial begin
    #2;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    send(8'hA5, 1'b1, 1'b0);
    chk("t1_pre_valid", rx_valid, 0);
    chk("t1_pre_busy", busy, 1);
    tick();
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_ferr", frame_err, 0);
    chk("t1_ovr", overrun, 0);
    chk("t1_busy", busy, 0);
    repeat (7) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("t1_consumed", rx_valid, 0);
    chk("t1_data_hold", rx_data, 8'hA5);
    repeat (4) tick();
    Rx_out = 1'b0;
    f_edge = 1'b1;
    tick();
    f_edge = 1'b0;
    repeat (3) tick();
    Rx_out = 1'b1;
    repeat (4) tick();
    chk("t2_busy_before", busy, 1);
    tick();
    chk("t2_busy_after", busy, 0);
    chk("t2_valid", rx_valid, 0);
    chk("t2_ferr", frame_err, 0);
    repeat (20) tick();
    send(8'h3C, 1'b0, 1'b0);
    tick();
    chk("t3_ferr", frame_err, 1);
    chk("t3_valid", rx_valid, 0);
    tick();
    chk("t3_ferr_pulse", frame_err, 0);
    Rx_out = 1'b1;
    repeat (20) tick();
    send(8'h55, 1'b1, 1'b0);
    tick();
    chk("t3_valid55", rx_valid, 1);
    chk("t3_data55", rx_data, 8'h55);
    chk("t3_ferr55", frame_err, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (5) tick();
    send(8'h11, 1'b1, 1'b0);
    tick();
    chk("t4_data11", rx_data, 8'h11);
    repeat (7) tick();
    send(8'h22, 1'b1, 1'b0);
    tick();
    chk("t4_ovr", overrun, 1);
    chk("t4_data22", rx_data, 8'h22);
    chk("t4_valid22", rx_valid, 1);
    tick();
    chk("t4_ovr_pulse", overrun, 0);
    rx_ready = 1'b1;
    repeat (6) tick();
    rx_ready = 1'b0;
    chk("t4_consumed", rx_valid, 0);
    send(8'h11, 1'b1, 1'b0);
    tick();
    chk("t4b_valid11", rx_valid, 1);
    repeat (7) tick();
    send(8'h22, 1'b1, 1'b0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("t4b_ovr", overrun, 0);
    chk("t4b_valid", rx_valid, 1);
    chk("t4b_data", rx_data, 8'h22);
    repeat (7) tick();
    Rx_out = 1'b0;
    f_edge = 1'b1;
    tick();
    f_edge = 1'b0;
    repeat (15) tick();
    Rx_out = 1'b1;
    repeat (48) tick();
    chk("t5_busy_mid", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", rx_valid, 0);
    chk("t5_rst_data", rx_data, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    send(8'h81, 1'b1, 1'b0);
    tick();
    chk("t5_valid81", rx_valid, 1);
    chk("t5_data81", rx_data, 8'h81);
`ifdef UART_RX_PARITY_EN
    rx_ready = 1'b1;
    repeat (7) tick();
    rx_ready = 1'b0;
    send(8'h07, 1'b1, 1'b0);
    tick();
    chk("t6_perr_ok", parity_err, 0);
    chk("t6_data_ok", rx_data, 8'h07);
    rx_ready = 1'b1;
    repeat (7) tick();
    rx_ready = 1'b0;
    send(8'h07, 1'b1, 1'b1);
    chk("t6_perr_pre", parity_err, 0);
    tick();
    chk("t6_perr", parity_err, 1);
    chk("t6_data", rx_data, 8'h07);
    chk("t6_valid", rx_valid, 1);
    tick();
    chk("t6_perr_pulse", parity_err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART input path. It consumes the synchronised serial line `Rx_out` and the one-cycle falling-edge strobe `f_edge` from the Rx input register stage. It times start, data and stop bits against a clock-count baud divider and assembles LSB-first data bytes. Completed bytes go into a one-deep holding register with a valid/ready handshake toward the microForth core.

Parameters:
CLKS_PER_BIT, 434, CLOCK cycles per bit (50 MHz / 115200); legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
CLOCK  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
Rx_out  in  1  synchronised serial line; idle high.
f_edge  in  1  one-cycle strobe on a line falling edge.
rx_ready  in  1  consumer accepts rx_data this cycle.
rx_data  out  DATA_BITS  received byte, LSB = first data bit.
rx_valid  out  1  rx_data holds an unconsumed byte.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  one-cycle pulse: unconsumed byte overwritten.
busy  out  1  high in every state except IDLE.

Behaviour:
- Single clock domain (CLOCK); reset is asynchronous and active-high.
- Reset values: state=IDLE, bit counter=0, clock counter=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- HALF = CLKS_PER_BIT/2, integer division.
- Clock counter width is clog2(CLKS_PER_BIT). It clears on every state transition and on every bit sample.
- IDLE: f_edge=1 -> START with counter=0. f_edge is ignored in all other states.
- START: counter increments each cycle. At counter==HALF-1, sample Rx_out:
  - Rx_out=0 -> DATA, bit index=0.
  - Rx_out=1 -> false start, return to IDLE; no output change.
- DATA: at counter==CLKS_PER_BIT-1, shift Rx_out in at the MSB end, right-shifting so the first bit lands at bit 0, and increment the bit index.
  - After DATA_BITS samples -> STOP (or PARITY when the optional feature is enabled).
- STOP: at counter==CLKS_PER_BIT-1, sample Rx_out, then go to IDLE in that same cycle.
  - Rx_out=1: commit. Next cycle rx_data=shift and rx_valid=1.
  - Rx_out=0: frame_err pulses for one cycle; byte discarded; rx_valid unchanged.
- Returning to IDLE at mid-stop-bit is required so a back-to-back start edge is not missed. A line held low (break) produces no new f_edge and therefore no retrigger.
- Handshake:
  - rx_valid & rx_ready clears rx_valid on the next edge.
  - rx_data is stable while rx_valid=1 with no commit.
  - Commit with rx_valid=1 and rx_ready=0: overwrite rx_data, rx_valid stays 1, overrun pulses.
  - Commit and consume in the same cycle: load new data, rx_valid stays 1, no overrun.
- Latency: rx_valid rises one cycle after the stop-sample cycle. That is about (DATA_BITS+1)*CLKS_PER_BIT + HALF cycles after the f_edge is accepted.
- busy is registered and equals (state != IDLE).
- Reset asserted mid-frame aborts immediately to reset values. After release, the first f_edge starts a new frame.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one bit at counter==CLKS_PER_BIT-1.
  - Even parity is checked: XOR of the data bits and the parity bit must equal 0.
  - A mismatch raises an extra output port parity_err, a one-cycle pulse in the cycle after the stop sample.
  - On a mismatch the byte is still committed.
- Undefined: no PARITY state and no parity_err port; the frame is start + DATA_BITS + stop.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - default CLKS_PER_BIT and DATA_BITS constants;
  - a clog2-based counter-width function.
- One natural sub-module, uart_baud_cnt: a loadable/clearable clock counter with terminal-count and half-count strobes, also reusable by the TX side.

Test Plan:
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8.
1. Frame 0xA5 (line 0, 1,0,1,0,0,1,0,1, 1) with rx_ready=0 -> rx_valid=1 and rx_data=0xA5 one cycle after the stop sample; no error pulses. Then rx_ready=1 for one cycle -> rx_valid=0.
2. Line low for 4 cycles then high (glitch) -> busy returns to 0 after the HALF-cycle sample; rx_valid stays 0; no pulses.
3. Frame 0x3C with the stop bit driven low -> frame_err pulses once; rx_valid stays 0; the next valid frame 0x55 is received normally.
4. Two back-to-back frames 0x11 then 0x22, rx_ready held 0 -> second commit gives overrun=1 for one cycle and rx_data=0x22. Repeat with rx_ready=1 on the commit cycle -> overrun=0 and rx_data=0x22.
5. Reset asserted mid-DATA (after 3 bits of 0xFF) -> all outputs 0 immediately. After release, frame 0x81 -> rx_data=0x81.
6. With UART_RX_PARITY_EN defined: 0x07 with parity 1 -> no parity_err. 0x07 with parity 0 -> parity_err pulses, rx_data=0x07.
